// File: rtl/w_clk_module.sv
// Write-clock-domain half of an asynchronous FIFO: write pointers, read-pointer sync and write-side status.
// Optional sticky overflow flag is compiled in with `define W_OVERFLOW_FLAG_EN.

module two_ff_synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule

module w_clk_module #(
    parameter int ADDRESS_SIZE = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  w_clk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic [ADDRESS_SIZE:0] r_ptr,
    output logic                  w_we,
    output logic [ADDRESS_SIZE-1:0] w_addr,
    output logic [ADDRESS_SIZE:0] w_ptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDRESS_SIZE:0] w_level,
    output logic                  w_overflow
);
    localparam int PW    = ADDRESS_SIZE + 1;
    localparam int DEPTH = 1 << ADDRESS_SIZE;
    localparam logic [PW-1:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic [PW-1:0] r_level;
    logic          r_full;
    logic          r_afull;

    logic          w_accept;
    logic [PW-1:0] w_bnext;
    logic [PW-1:0] w_gnext;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] wq2_rbin;
    logic [PW-1:0] w_full_cmp;
    logic [PW-1:0] w_diff;

    assign w_accept = w_en & ~r_full;
    // Gated by reset so the memory never sees a write while the block is held in reset.
    assign w_we     = w_accept & wrst_n;
    assign w_bnext  = r_bin + {{(PW-1){1'b0}}, w_accept};
    assign w_gnext  = w_bnext ^ (w_bnext >> 1);

    two_ff_synchronizer #(.WIDTH(PW)) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (wrst_n),
        .d     (r_ptr),
        .q     (wq2_rptr)
    );

    // Each binary bit is the XOR of all Gray bits at and above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wq2_rbin[gi] = ^(wq2_rptr >> gi);
        end
    endgenerate

    // Full when the next write pointer is exactly one lap ahead of the synchronised read pointer.
    assign w_full_cmp = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    assign w_diff     = w_bnext - wq2_rbin;

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
        end else begin
            r_bin   <= w_bnext;
            r_gray  <= w_gnext;
            r_full  <= (w_gnext == w_full_cmp);
            r_afull <= (w_diff >= AFULL_THRESH);
            r_level <= w_diff;
        end
    end

`ifdef W_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_overflow <= 1'b0;
        end else if (w_en & r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_overflow = r_overflow;
`else
    assign w_overflow = 1'b0;
`endif

    assign w_addr        = r_bin[ADDRESS_SIZE-1:0];
    assign w_ptr         = r_gray;
    assign w_full        = r_full;
    assign w_almost_full = r_afull;
    assign w_level       = r_level;
endmodule

// File: tb/tb_w_clk_module.sv
// Self-checking bench for w_clk_module (ADDRESS_SIZE=4, AFULL_MARGIN=2): vector table,
// hand-written corner sequences and randomized traffic against an occupancy-count model.
module tb_w_clk_module;
    localparam int AS = 4;
    localparam int PW = AS + 1;

    logic          w_clk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          w_en = 1'b0;
    logic [PW-1:0] r_ptr = '0;
    logic          w_we;
    logic [AS-1:0] w_addr;
    logic [PW-1:0] w_ptr;
    logic          w_full;
    logic          w_almost_full;
    logic [PW-1:0] w_level;
    logic          w_overflow;

    w_clk_module #(.ADDRESS_SIZE(AS), .AFULL_MARGIN(2)) dut (
        .w_clk         (w_clk),
        .wrst_n        (wrst_n),
        .w_en          (w_en),
        .r_ptr         (r_ptr),
        .w_we          (w_we),
        .w_addr        (w_addr),
        .w_ptr         (w_ptr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow)
    );

    always #5 w_clk = ~w_clk;

    int errors = 0;
    int checks = 0;

`ifdef W_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // Model: count of accepted writes (mod 32), read-pointer values seen through two edges of delay.
    int            m_wc;
    int            m_level;
    bit            m_full;
    bit            m_afull;
    bit            m_ovf;
    logic [PW-1:0] m_s1;
    logic [PW-1:0] m_s2;

    function automatic logic [PW-1:0] gray(input int b);
        int v;
        v = b % 32;
        return PW'(v ^ (v >> 1));
    endfunction

    function automatic int g2b(input logic [PW-1:0] g);
        for (int b = 0; b < 32; b++)
            if (gray(b) == g) return b;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wc = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        m_s1 = '0; m_s2 = '0;
    endtask

    task automatic model_edge();
        int occ;
        if (OVF_EN && w_en && m_full) m_ovf = 1;
        if (w_en && !m_full) m_wc = (m_wc + 1) % 32;
        occ     = (m_wc - g2b(m_s2) + 32) % 32;
        if (occ == 0 && m_wc != g2b(m_s2)) occ = 32;
        m_level = occ;
        m_full  = (occ == 16);
        m_afull = (occ >= 14);
        m_s2    = m_s1;
        m_s1    = r_ptr;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".full"},  int'(w_full),        int'(m_full));
        chk({tag, ".afull"}, int'(w_almost_full), int'(m_afull));
        chk({tag, ".level"}, int'(w_level),       m_level);
        chk({tag, ".ptr"},   int'(w_ptr),         int'(gray(m_wc)));
        chk({tag, ".addr"},  int'(w_addr),        m_wc % 16);
        chk({tag, ".ovf"},   int'(w_overflow),    int'(m_ovf));
    endtask

    // One clock of traffic: w_we checked before the edge, everything else after it.
    task automatic step(input string tag);
        #1;
        chk({tag, ".we"}, int'(w_we), int'(w_en && !m_full && wrst_n));
        @(posedge w_clk);
        model_edge();
        #1;
        check_outputs(tag);
        $display("%s t=%0t en=%0b rptr=%05b addr=%0d ptr=%05b level=%0d full=%0b afull=%0b ovf=%0b",
                 tag, $time, w_en, r_ptr, w_addr, w_ptr, w_level, w_full, w_almost_full, w_overflow);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 wrst_n = 1'b0;
        r_ptr = '0;
        #1;
        model_reset();
        check_outputs(tag);
        chk({tag, ".we"}, int'(w_we), 0);
        wrst_n = 1'b1;
    endtask

    typedef struct {
        bit            en;
        logic [PW-1:0] rptr;
        bit            we;
        int            level;
        bit            full;
        bit            afull;
        int            addr;
        logic [PW-1:0] ptr;
        bit            ovf;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int rd;
        // Fill to full (16 writes + 1 refused), then release with r_ptr = gray(4).
        for (int k = 0; k < 20; k++) begin
            int n;
            n = (k + 1 > 16) ? 16 : k + 1;
            tbl[k].en    = (k < 17);
            tbl[k].rptr  = (k < 17) ? 5'b00000 : 5'b00110;
            tbl[k].we    = (k < 16);
            tbl[k].level = (k < 19) ? n : 12;
            tbl[k].full  = (k >= 15 && k < 19);
            tbl[k].afull = (k >= 13 && k < 19);
            tbl[k].addr  = n % 16;
            tbl[k].ptr   = (n == 16) ? 5'b11000 : gray(n);
            tbl[k].ovf   = OVF_EN && (k >= 16);
        end

        model_reset();
        // Reset held with traffic on the inputs.
        wrst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_en  = 1'b1;
            r_ptr = PW'($urandom);
            #1;
            check_outputs("reset");
            chk("reset.we", int'(w_we), 0);
            @(posedge w_clk);
            #1;
            check_outputs("reset");
        end
        r_ptr = '0;
        w_en  = 1'b0;
        wrst_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            w_en  = tbl[k].en;
            r_ptr = tbl[k].rptr;
            #1;
            chk("tbl.we", int'(w_we), int'(tbl[k].we));
            step("tbl");
            chk("tbl.level", int'(w_level), tbl[k].level);
            chk("tbl.full",  int'(w_full), int'(tbl[k].full));
            chk("tbl.afull", int'(w_almost_full), int'(tbl[k].afull));
            chk("tbl.addr",  int'(w_addr), tbl[k].addr);
            chk("tbl.ptr",   int'(w_ptr), int'(tbl[k].ptr));
            chk("tbl.ovf",   int'(w_overflow), int'(tbl[k].ovf));
        end

        // Wrap: reader keeps pace with the writer.
        async_reset_pulse("wrap_rst");
        w_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r_ptr = gray(m_wc);
            step("wrap");
            chk("wrap.addr_seq", int'(w_addr), (i + 1) % 16);
            chk("wrap.msb", int'(w_ptr[PW-1]), ((i + 1) / 16) % 2);
        end

        // Reset mid-burst at level 9, then first write goes to address 0.
        async_reset_pulse("mid_rst0");
        w_en = 1'b1;
        for (int i = 0; i < 9; i++) step("burst");
        chk("burst.level9", int'(w_level), 9);
        async_reset_pulse("mid_rst");
        #1;
        chk("mid_rst.addr0", int'(w_addr), 0);
        step("after_rst");

        // Randomized traffic with a slow reader so full and overflow are exercised.
        async_reset_pulse("rand_rst");
        rd = 0;
        for (int i = 0; i < 200; i++) begin
            w_en = ($urandom % 4) != 0;
            if (($urandom % 3) == 0 && rd != m_wc) rd = (rd + 1) % 32;
            r_ptr = gray(rd);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
